imm_gen_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the ID stage. Takes a RISC-V

---
 rtl/imm_gen_pipe.sv | 140 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator for the ID stage.
// One-cycle latency, valid/ready on both sides, skid entry keeps in_ready registered.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_func,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [63:0]      gen_imm64;
    logic [XLEN-1:0]  gen_imm;
    logic             gen_err;

    always_comb begin
        gen_imm64 = '0;
        gen_err   = 1'b0;
        case (in_func)
            3'b001: gen_imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
            3'b010: gen_imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
            3'b011: gen_imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                                 in_inst[30:25], in_inst[11:8], 1'b0};
            3'b100: gen_imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                 in_inst[20], in_inst[30:21], 1'b0};
            3'b101: gen_imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'b110: gen_imm64 = {59'b0, in_inst[19:15]};
            3'b111: begin
                // RV32 shifts only have 5 shamt bits; bit 25 set is illegal there
                if (XLEN == 64) begin
                    gen_imm64 = {58'b0, in_inst[25:20]};
                end else begin
                    gen_imm64 = {59'b0, in_inst[24:20]};
                    gen_err   = in_inst[25];
                end
            end
            default: gen_err = 1'b1;
        endcase
        if (gen_err) begin
            gen_imm64 = '0;
        end
    end

    assign gen_imm = gen_imm64[XLEN-1:0];

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic             out_err_q, out_err_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic             skid_err_q, skid_err_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_fire;
    logic             main_free;

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign main_free = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            // skid is older than any new beat, and in_ready is low while it is full
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_err_d    = skid_err_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_imm_d   = gen_imm;
                out_err_d   = gen_err;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = gen_imm;
            skid_err_d   = gen_err;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_err   = out_err_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed spec vectors plus a randomized
// scoreboard run, on an XLEN=64 and an XLEN=32 instance sharing inputs.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready, in_ready32;
    logic [31:0] in_inst;
    logic [2:0]  in_func;
    logic [63:0] in_tag;
    logic        out_valid, out_valid32;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [31:0] out_imm32;
    logic        out_err, out_err32;
    logic [63:0] out_tag, out_tag32;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] imm64;
        logic        err64;
        logic [63:0] imm32;
        logic        err32;
        logic [63:0] tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_func(in_func), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_err(out_err), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(64)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_func(in_func), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_err(out_err32), .out_tag(out_tag32)
    );

    // Reference: value of the immediate as a signed number, then truncated.
    function automatic logic [64:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] f,
                                            input int xlen);
        longint v;
        logic   e;
        logic [12:0] b;
        logic [20:0] j;
        logic [63:0] r;
        v = 0;
        e = 1'b0;
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (f)
            3'd1: v = longint'($signed(i[31:20]));
            3'd2: v = longint'($signed(i)) - longint'(i[11:0]);
            3'd3: v = longint'($signed(b));
            3'd4: v = longint'($signed(j));
            3'd5: v = longint'($signed({i[31:25], i[11:7]}));
            3'd6: v = longint'(i[19:15]);
            3'd7: begin
                if (xlen == 64) v = longint'(i[25:20]);
                else begin
                    v = longint'(i[24:20]);
                    e = i[25];
                end
            end
            default: e = 1'b1;
        endcase
        if (e) v = 0;
        r = v;
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return {e, r};
    endfunction

    function automatic exp_t make_exp(input logic [31:0] i,
                                      input logic [2:0] f,
                                      input logic [63:0] t);
        exp_t x;
        logic [64:0] r;
        r = ref_imm(i, f, 64);
        x.imm64 = r[63:0];
        x.err64 = r[64];
        r = ref_imm(i, f, 32);
        x.imm32 = r[63:0];
        x.err32 = r[64];
        x.tag = t;
        return x;
    endfunction

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        in_func  = '0;
        in_tag   = '0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 64'h0 ||
            out_err !== 1'b0 || out_tag !== 64'h0) begin
            fails++;
            $display("FAIL reset: v=%b rdy=%b imm=%h err=%b tag=%h want 0 1 0 0 0",
                     out_valid, in_ready, out_imm, out_err, out_tag);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_valid32 !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: v=%b rdy=%b v32=%b want 0 1 0",
                     out_valid, in_ready, out_valid32);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vi[8];
        logic [2:0]  vf[8];
        logic [63:0] e64[8];
        logic        r64[8];
        logic [31:0] e32[8];
        logic        r32[8];
        vi[0] = 32'hFFF00093; vf[0] = 3'd1; e64[0] = 64'hFFFFFFFFFFFFFFFF; r64[0] = 0;
        e32[0] = 32'hFFFFFFFF; r32[0] = 0;
        vi[1] = 32'h800000B7; vf[1] = 3'd2; e64[1] = 64'hFFFFFFFF80000000; r64[1] = 0;
        e32[1] = 32'h80000000; r32[1] = 0;
        vi[2] = 32'hFE000EE3; vf[2] = 3'd3; e64[2] = 64'hFFFFFFFFFFFFFFFC; r64[2] = 0;
        e32[2] = 32'hFFFFFFFC; r32[2] = 0;
        vi[3] = 32'h03F00013; vf[3] = 3'd7; e64[3] = 64'h3F; r64[3] = 0;
        e32[3] = 32'h0; r32[3] = 1;
        vi[4] = 32'h01F00013; vf[4] = 3'd7; e64[4] = 64'h1F; r64[4] = 0;
        e32[4] = 32'h1F; r32[4] = 0;
        vi[5] = 32'hFFFFFFFF; vf[5] = 3'd0; e64[5] = 64'h0; r64[5] = 1;
        e32[5] = 32'h0; r32[5] = 1;
        vi[6] = 32'hFFFFFFFF; vf[6] = 3'd6; e64[6] = 64'h1F; r64[6] = 0;
        e32[6] = 32'h1F; r32[6] = 0;
        vi[7] = 32'h800000EF; vf[7] = 3'd4; e64[7] = 64'hFFFFFFFFFFF00000; r64[7] = 0;
        e32[7] = 32'hFFF00000; r32[7] = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_inst  = vi[k];
            in_func  = vf[k];
            in_tag   = 64'h1000 + 64'(k);
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            tests++;
            if (out_valid !== 1'b1 || out_imm !== e64[k] || out_err !== r64[k] ||
                out_tag !== 64'h1000 + 64'(k)) begin
                fails++;
                $display("FAIL vec64[%0d]: v=%b imm=%h err=%b tag=%h want 1 %h %b %h",
                         k, out_valid, out_imm, out_err, out_tag, e64[k], r64[k],
                         64'h1000 + 64'(k));
            end
            tests++;
            if (out_valid32 !== 1'b1 || out_imm32 !== e32[k] || out_err32 !== r32[k]) begin
                fails++;
                $display("FAIL vec32[%0d]: v=%b imm=%h err=%b want 1 %h %b",
                         k, out_valid32, out_imm32, out_err32, e32[k], r32[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] tags[3];
        tags[0] = 64'hA; tags[1] = 64'hB; tags[2] = 64'hC;
        idle_inputs();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_func = 3'd1; in_tag = tags[0];
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== tags[0]) begin
            fails++;
            $display("FAIL b2b_a: rdy=%b v=%b tag=%h want 1 1 %h",
                     in_ready, out_valid, out_tag, tags[0]);
        end
        in_inst = 32'h00200093; in_tag = tags[1];
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_tag !== tags[0] || out_imm !== 64'h1) begin
            fails++;
            $display("FAIL b2b_full: rdy=%b tag=%h imm=%h want 0 %h 1",
                     in_ready, out_tag, out_imm, tags[0]);
        end
        in_inst = 32'h00300093; in_tag = tags[2];
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_tag !== tags[0] || out_imm !== 64'h1) begin
            fails++;
            $display("FAIL b2b_hold: rdy=%b tag=%h imm=%h want 0 %h 1",
                     in_ready, out_tag, out_imm, tags[0]);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_tag !== tags[k] || out_imm !== 64'(k + 1)) begin
                fails++;
                $display("FAIL b2b_order[%0d]: v=%b tag=%h imm=%h want 1 %h %h",
                         k, out_valid, out_tag, out_imm, tags[k], 64'(k + 1));
            end
            if (k == 1) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_rdy: rdy=%b want 1", in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_empty: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        int bad_rdy = 0;
        int bad_tag = 0;
        idle_inputs();
        in_func = 3'd1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (in_ready !== 1'b1) bad_rdy++;
                if (out_valid !== 1'b1 || out_tag !== 64'(k + 99)) bad_tag++;
            end
            in_valid = 1'b1;
            in_inst  = $urandom;
            in_tag   = 64'(k + 100);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (bad_rdy != 0 || bad_tag != 0 || out_tag !== 64'd119) begin
            fails++;
            $display("FAIL stream: bad_rdy=%0d bad_tag=%0d last_tag=%0d want 0 0 119",
                     bad_rdy, bad_tag, out_tag);
        end
        @(negedge clk);
    endtask

    task automatic fill_both();
        idle_inputs();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_func = 3'd1; in_tag = 64'h55;
        @(negedge clk);
        in_tag = 64'h66;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        fill_both();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL flush_pre: rdy=%b v=%b want 0 1", in_ready, out_valid);
        end
        flush = 1'b1;
        in_valid = 1'b1; in_tag = 64'h77;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush: v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_stale: v=%b tag=%h want 0", out_valid, out_tag);
        end
    endtask

    task automatic test_async_reset();
        fill_both();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 64'h0 ||
            out_tag !== 64'h0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: v=%b rdy=%b imm=%h tag=%h err=%b want 0 1 0 0 0",
                     out_valid, in_ready, out_imm, out_tag, out_err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_rst_stale: v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int   bad = 0;
        bit   acc, drn;
        exp_t x;
        idle_inputs();
        q.delete();
        @(negedge clk);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
                out_valid32 !== (q.size() != 0)) begin
                fails++;
                bad++;
                $display("FAIL rand_hs[%0d]: v=%b rdy=%b v32=%b model_depth=%0d",
                         n, out_valid, in_ready, out_valid32, q.size());
            end
            if (q.size() != 0) begin
                x = q[0];
                tests++;
                if (out_imm !== x.imm64 || out_err !== x.err64 || out_tag !== x.tag ||
                    out_imm32 !== x.imm32[31:0] || out_err32 !== x.err32 ||
                    out_tag32 !== x.tag) begin
                    fails++;
                    bad++;
                    $display("FAIL rand_data[%0d]: imm=%h err=%b tag=%h imm32=%h err32=%b want %h %b %h %h %b",
                             n, out_imm, out_err, out_tag, out_imm32, out_err32,
                             x.imm64, x.err64, x.tag, x.imm32[31:0], x.err32);
                end
            end
            if (bad > 10) break;
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = $urandom;
            in_func   = 3'($urandom_range(0, 7));
            in_tag    = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() != 0);
            if (flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(make_exp(in_inst, in_func, in_tag));
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stream();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
